// File: rtl/mem_stage_lsu_pkg.sv
// Shared encodings for the M-stage load/store unit: funct3 access codes,
// FSM states and the access-size helpers used by the datapath.
package mem_stage_lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {
        LSU_IDLE,
        LSU_ACCESS
    } lsu_state_e;

    typedef enum logic [1:0] {
        SIZE_BYTE,
        SIZE_HALF,
        SIZE_WORD
    } access_size_e;

    // Unlisted funct3 codes fall back to full-word accesses.
    function automatic access_size_e accessSize(input logic [2:0] funct3);
        case (funct3)
            F3_LB, F3_LBU: accessSize = SIZE_BYTE;
            F3_LH, F3_LHU: accessSize = SIZE_HALF;
            default:       accessSize = SIZE_WORD;
        endcase
    endfunction

    function automatic logic isMisaligned(input access_size_e size, input logic [1:0] lowAddr);
        case (size)
            SIZE_HALF: isMisaligned = lowAddr[0];
            SIZE_WORD: isMisaligned = |lowAddr;
            default:   isMisaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_data_mem.sv
// Word-organised data memory: synchronous byte-enable write, combinational read.
// Contents are deliberately not reset.
module lsu_data_mem #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [XLEN/8-1:0] be_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [XLEN-1:0]   wdata_i,
    output logic [XLEN-1:0]   rdata_o
);

    logic [XLEN-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < XLEN / 8; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit: multi-cycle memory access FSM, alignment check,
// load extension and the MEM/WB pipeline register.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 256,
    parameter int MEM_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_m,
    input  logic            flush,
    input  logic            mem_read_m,
    input  logic            mem_write_m,
    input  logic            mem_to_reg_m,
    input  logic            reg_write_m,
    input  logic [2:0]      funct3_m,
    input  logic [4:0]      rd_m,
    input  logic [XLEN-1:0] alu_out_m,
    input  logic [XLEN-1:0] write_data_m,
    output logic            stall_m,
    output logic            valid_w,
    output logic [XLEN-1:0] read_data_w,
    output logic [XLEN-1:0] alu_out_w,
    output logic [4:0]      rd_w,
    output logic            mem_to_reg_w,
    output logic            reg_write_w,
    output logic            misalign_w
);

    localparam int AW = $clog2(DEPTH);
    localparam int NB = XLEN / 8;
    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    lsu_state_e      state_q, state_d;
    logic [3:0]      count_q, count_d;
    access_size_e    size;
    logic            live, memOp, misaligned, accessGo, stallRaw, memWe;
    logic [NB-1:0]   memBe;
    logic [XLEN-1:0] memWdata, memRdata, laneShifted, loadData;

    logic            validW_q, regWriteW_q, memToRegW_q, misalignW_q;
    logic [4:0]      rdW_q;
    logic [XLEN-1:0] readDataW_q, aluOutW_q;

    assign live       = valid_m & ~flush;
    assign memOp      = mem_read_m | mem_write_m;
    assign size       = accessSize(funct3_m);
    assign misaligned = isMisaligned(size, alu_out_m[1:0]);
    assign accessGo   = live & memOp & ~misaligned;

    // The entry cycle behaves as if the counter already holds MEM_LAT-1,
    // so MEM_LAT=1 completes without ever leaving IDLE.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        stallRaw = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                if (accessGo && (LAT_M1 != 4'd0)) begin
                    stallRaw = 1'b1;
                    state_d  = LSU_ACCESS;
                    count_d  = LAT_M1 - 4'd1;
                end
            end
            LSU_ACCESS: begin
                if (!accessGo) begin
                    state_d = LSU_IDLE;
                    count_d = 4'd0;
                end else if (count_q != 4'd0) begin
                    stallRaw = 1'b1;
                    count_d  = count_q - 4'd1;
                end else begin
                    state_d = LSU_IDLE;
                end
            end
            default: begin
                state_d = LSU_IDLE;
                count_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LSU_IDLE;
            count_q <= 4'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Gating with rst keeps an access abandoned by reset from writing memory.
    assign stall_m = stallRaw & rst;
    assign memWe   = accessGo & mem_write_m & ~stallRaw & rst;

    always_comb begin
        memBe    = '1;
        memWdata = write_data_m;
        case (size)
            SIZE_BYTE: begin
                memBe    = NB'(1) << alu_out_m[1:0];
                memWdata = {NB{write_data_m[7:0]}};
            end
            SIZE_HALF: begin
                memBe    = alu_out_m[1] ? NB'(4'b1100) : NB'(4'b0011);
                memWdata = {(NB/2){write_data_m[15:0]}};
            end
            default: begin
                memBe    = '1;
                memWdata = write_data_m;
            end
        endcase
    end

    lsu_data_mem #(
        .XLEN (XLEN),
        .DEPTH(DEPTH)
    ) u_data_mem (
        .clk_i  (clk),
        .we_i   (memWe),
        .be_i   (memBe),
        .addr_i (alu_out_m[AW+1:2]),
        .wdata_i(memWdata),
        .rdata_o(memRdata)
    );

    assign laneShifted = memRdata >> {alu_out_m[1:0], 3'b000};

    always_comb begin
        loadData = memRdata;
        case (funct3_m)
            F3_LB:   loadData = {{(XLEN-8){laneShifted[7]}}, laneShifted[7:0]};
            F3_LH:   loadData = {{(XLEN-16){laneShifted[15]}}, laneShifted[15:0]};
            F3_LBU:  loadData = {{(XLEN-8){1'b0}}, laneShifted[7:0]};
            F3_LHU:  loadData = {{(XLEN-16){1'b0}}, laneShifted[15:0]};
            default: loadData = memRdata;
        endcase
    end

    // While stalled, W presents a held bubble so writeback never repeats.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            validW_q    <= 1'b0;
            regWriteW_q <= 1'b0;
            memToRegW_q <= 1'b0;
            misalignW_q <= 1'b0;
            rdW_q       <= 5'd0;
            readDataW_q <= '0;
            aluOutW_q   <= '0;
        end else if (stallRaw) begin
            validW_q    <= 1'b0;
            regWriteW_q <= 1'b0;
            misalignW_q <= 1'b0;
        end else begin
            validW_q    <= live;
            regWriteW_q <= live & reg_write_m & ~(memOp & misaligned);
            memToRegW_q <= live & mem_to_reg_m;
            misalignW_q <= live & memOp & misaligned;
            rdW_q       <= rd_m;
            readDataW_q <= loadData;
            aluOutW_q   <= alu_out_m;
        end
    end

    assign valid_w      = validW_q;
    assign reg_write_w  = regWriteW_q;
    assign mem_to_reg_w = memToRegW_q;
    assign misalign_w   = misalignW_q;
    assign rd_w         = rdW_q;
    assign read_data_w  = readDataW_q;
    assign alu_out_w    = aluOutW_q;

endmodule
